// File: rtl/clk_div_pkg.sv
// Shared types and default widths for the clock divider family and its meter.
package clk_div_pkg;

  localparam int unsigned DIV_CNT_W       = 16;
  localparam int unsigned DIV_LOCK_CNT    = 4;
  localparam int unsigned DIV_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2
  } meter_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronises an asynchronous level into clk and emits registered edge pulses.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : asynchronous input level
//   rise, fall : one-cycle pulses on a synchronised 0->1 / 1->0 change;
//                input-to-pulse latency is STAGES+1 clk cycles
module sync_edge_det #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Synchroniser chain, history flop and registered edge pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      hist_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~hist_q;
      fall   <= ~sync_q[STAGES-1] & hist_q;
    end
  end

endmodule

// File: rtl/clk_div_meter.sv
// Period / high-time meter and lock detector for a slow clock-like input.
// Build option: CLK_DIV_METER_DUTY_EN enables fall detection and high_time;
// without it high_time is tied to 0.
// Ports:
//   clk, rst_n : measurement clock, asynchronous active-low reset
//   en         : level-sensitive measurement enable
//   clk_in     : clock under test (asynchronous to clk)
//   period     : last measured rise-to-rise period in clk cycles
//   high_time  : rise-to-fall time of the reported period
//   meas_valid : one-cycle pulse when period/high_time update
//   locked     : period stable over LOCK_CNT consecutive measurements
//   timeout    : sticky, counter saturated without a rising edge
module clk_div_meter
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = DIV_CNT_W,
  parameter int unsigned LOCK_CNT    = DIV_LOCK_CNT,
  parameter int unsigned SYNC_STAGES = DIV_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int unsigned      LCNT_W   = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [LCNT_W-1:0] LOCK_MAX = LCNT_W'(LOCK_CNT - 1);

  meter_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              valid_q, valid_d;
  logic              locked_q, locked_d;
  logic              timeout_q, timeout_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic              rise;

`ifdef CLK_DIV_METER_DUTY_EN
  logic              fall;
  logic [CNT_W-1:0]  hlat_q, hlat_d;
  logic [CNT_W-1:0]  high_q, high_d;
  logic              fall_seen_q, fall_seen_d;
`else
  logic              fall_unused;
`endif

  sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (clk_in),
    .rise  (rise),
`ifdef CLK_DIV_METER_DUTY_EN
    .fall  (fall)
`else
    .fall  (fall_unused)
`endif
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      lcnt_q      <= '0;
`ifdef CLK_DIV_METER_DUTY_EN
      hlat_q      <= '0;
      high_q      <= '0;
      fall_seen_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
      lcnt_q      <= lcnt_d;
`ifdef CLK_DIV_METER_DUTY_EN
      hlat_q      <= hlat_d;
      high_q      <= high_d;
      fall_seen_q <= fall_seen_d;
`endif
    end
  end

  // Next-state and next-value logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    timeout_d   = timeout_q;
    lcnt_d      = lcnt_q;
`ifdef CLK_DIV_METER_DUTY_EN
    hlat_d      = hlat_q;
    high_d      = high_q;
    fall_seen_d = fall_seen_q;
`endif

    if (!en) begin
      state_d   = IDLE;
      locked_d  = 1'b0;
      timeout_d = 1'b0;
      lcnt_d    = '0;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT_RISE;

        // First edge only starts the counter; nothing is reported for it
        WAIT_RISE: begin
          if (rise) begin
            state_d     = MEASURE;
            cnt_d       = CNT_ONE;
            timeout_d   = 1'b0;
`ifdef CLK_DIV_METER_DUTY_EN
            fall_seen_d = 1'b0;
`endif
          end
        end

        MEASURE: begin
          // A rise on the saturation cycle is still a valid measurement
          if (rise) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            cnt_d    = CNT_ONE;
`ifdef CLK_DIV_METER_DUTY_EN
            // No fall seen: input stayed high for the whole period
            high_d      = fall_seen_q ? hlat_q : cnt_q;
            fall_seen_d = 1'b0;
`endif
            if (cnt_q == period_q) begin
              if (lcnt_q != LOCK_MAX) begin
                lcnt_d = lcnt_q + LCNT_W'(1);
              end
              locked_d = (lcnt_d == LOCK_MAX);
            end else begin
              lcnt_d   = '0;
              locked_d = 1'b0;
            end
          end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            lcnt_d    = '0;
            state_d   = WAIT_RISE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
`ifdef CLK_DIV_METER_DUTY_EN
            if (fall) begin
              hlat_d      = cnt_q;
              fall_seen_d = 1'b1;
            end
`endif
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign period     = period_q;
  assign meas_valid = valid_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;
`ifdef CLK_DIV_METER_DUTY_EN
  assign high_time  = high_q;
`else
  assign high_time  = '0;
`endif

endmodule
